// File: rtl/q_sign_scaler.sv
// Sign-selected Q(INT_W).(FRAC_W) scaler: A<0 -> C = A >>> sh, A>0 -> C = B <<< sh (saturating), A==0 -> C = 0.
// Optional macro Q_SCALE_ROUND_EN: DIV results are rounded half-up using the last bit shifted out.
module q_sign_scaler #(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8,
    parameter int SHW    = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      start,
    input  logic [INT_W+FRAC_W-1:0]   A,
    input  logic [INT_W+FRAC_W-1:0]   B,
    input  logic [SHW-1:0]            sh,
    output logic                      busy,
    output logic                      done,
    output logic [INT_W+FRAC_W-1:0]   C,
    output logic [1:0]                sel,
    output logic                      ovf
);

    localparam int W = INT_W + FRAC_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_CLR = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10
    } op_t;

    // Saturation bound with the sign of the operand being shifted.
    function automatic logic [W-1:0] sat_value(input logic neg);
        logic [W-1:0] v;
        if (neg) begin
            v = {1'b1, {(W-1){1'b0}}};
        end else begin
            v = {1'b0, {(W-1){1'b1}}};
        end
        return v;
    endfunction

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [W-1:0]   ra_q, ra_d;
    logic [W-1:0]   rb_q, rb_d;
    logic [W-1:0]   rc_q, rc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic           sat_q, sat_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   c_q, c_d;
    logic [1:0]     sel_q, sel_d;
    logic           ovf_q, ovf_d;

    logic [W-1:0]   rc_step;
    logic           sat_step;
    logic [W-1:0]   rc_eval;
    op_t            op_eval;
    logic [W-1:0]   shift_result;
    logic           last_step;

`ifdef Q_SCALE_ROUND_EN
    logic           guard_q, guard_d;
    logic           guard_step;
`endif

    // One shift step of RC for the current operation.
    always_comb begin
        rc_step  = rc_q;
        sat_step = sat_q;
`ifdef Q_SCALE_ROUND_EN
        guard_step = guard_q;
`endif
        case (op_q)
            OP_DIV: begin
                rc_step = {rc_q[W-1], rc_q[W-1:1]};
`ifdef Q_SCALE_ROUND_EN
                guard_step = rc_q[0];
`endif
            end
            OP_MUL: begin
                // Once saturated, the bound is held for the remaining steps.
                if ((rc_q[W-1] != rc_q[W-2]) || sat_q) begin
                    rc_step  = sat_value(rc_q[W-1]);
                    sat_step = 1'b1;
                end else begin
                    rc_step  = {rc_q[W-2:0], 1'b0};
                    sat_step = sat_q;
                end
            end
            default: begin
                rc_step  = rc_q;
                sat_step = sat_q;
            end
        endcase
    end

    // Result presented on the final shift step; rounding adds the last bit shifted out.
    always_comb begin
`ifdef Q_SCALE_ROUND_EN
        if (op_q == OP_DIV) begin
            shift_result = rc_step + {{(W-1){1'b0}}, guard_step};
        end else begin
            shift_result = rc_step;
        end
`else
        shift_result = rc_step;
`endif
        last_step = (cnt_q == {{(SHW-1){1'b0}}, 1'b1});
    end

    // Operation classification from the latched selector operand.
    always_comb begin
        if (ra_q[W-1]) begin
            op_eval = OP_DIV;
            rc_eval = ra_q;
        end else if (ra_q == {W{1'b0}}) begin
            op_eval = OP_CLR;
            rc_eval = {W{1'b0}};
        end else begin
            op_eval = OP_MUL;
            rc_eval = rb_q;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        c_d     = c_q;
        sel_d   = sel_q;
        ovf_d   = ovf_q;
`ifdef Q_SCALE_ROUND_EN
        guard_d = guard_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ra_d    = A;
                    rb_d    = B;
                    cnt_d   = sh;
                    state_d = S_EVAL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EVAL: begin
                op_d  = op_eval;
                rc_d  = rc_eval;
                sat_d = 1'b0;
`ifdef Q_SCALE_ROUND_EN
                guard_d = 1'b0;
`endif
                if ((op_eval == OP_CLR) || (cnt_q == {SHW{1'b0}})) begin
                    state_d = S_DONE;
                    c_d     = rc_eval;
                    sel_d   = op_eval;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                rc_d  = rc_step;
                sat_d = sat_step;
                cnt_d = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
`ifdef Q_SCALE_ROUND_EN
                guard_d = guard_step;
`endif
                if (last_step) begin
                    state_d = S_DONE;
                    c_d     = shift_result;
                    sel_d   = op_q;
                    ovf_d   = sat_step;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_EVAL) || (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            op_q    <= OP_CLR;
            ra_q    <= {W{1'b0}};
            rb_q    <= {W{1'b0}};
            rc_q    <= {W{1'b0}};
            cnt_q   <= {SHW{1'b0}};
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= {W{1'b0}};
            sel_q   <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_q     <= c_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef Q_SCALE_ROUND_EN
    // Last bit shifted out of a DIV, used for round-half-up.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            guard_q <= 1'b0;
        end else begin
            guard_q <= guard_d;
        end
    end
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign C    = c_q;
    assign sel  = sel_q;
    assign ovf  = ovf_q;

endmodule
